// File: rtl/acl_rule_sequencer.sv
// ---------------------------------------------------------------------------
// acl_rule_sequencer
//   Walks the ACL rule table one rule at a time: fetches each rule word from
//   the rule RAM, presents it to the match engine, and waits for the engine's
//   verdict. The walk stops at the first hit or at the end of the table.
//
// Ports
//   ACLK, ARESETN        clock, asynchronous active-low reset
//   cfg_start            1-cycle start pulse (only honoured in IDLE)
//   cfg_abort            abort the walk; wins over every other event
//   cfg_base_addr        RAM address of rule 0, sampled on start
//   cfg_num_rules        number of rules to walk, sampled on start
//   mem_rd_en/addr/data  rule RAM read port (data valid MEM_LAT cycles later)
//   rule_valid/ready     rule handshake towards the match engine
//   rule_data/index      current rule word and its table-relative index
//   match_valid/hit      1-cycle verdict for the last accepted rule
//   busy, done           walk in progress / 1-cycle end-of-walk pulse
//   hit, hit_index       result of the last walk, held until next start
//   fsm_state            current FSM state (debug visibility)
//
// Handshake: a rule transfers on the rising edge where rule_valid and
// rule_ready are both high. rule_valid, rule_data and rule_index stay stable
// from the first valid cycle until that edge; rule_valid never depends
// combinationally on rule_ready.
// ---------------------------------------------------------------------------
module acl_rule_sequencer #(
  parameter int RULE_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [ADDR_W:0]   cfg_num_rules,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [RULE_W-1:0] mem_rd_data,
  output logic              rule_valid,
  input  logic              rule_ready,
  output logic [RULE_W-1:0] rule_data,
  output logic [ADDR_W-1:0] rule_index,
  input  logic              match_valid,
  input  logic              match_hit,
  output logic              busy,
  output logic              done,
  output logic              hit,
  output logic [ADDR_W-1:0] hit_index,
  output logic [2:0]        fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_FETCH       = 3'd1,
    S_WAIT_DATA   = 3'd2,
    S_PRESENT     = 3'd3,
    S_WAIT_RESULT = 3'd4,
    S_DONE        = 3'd5
  } state_t;

  localparam logic [ADDR_W:0] TABLE_DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [2:0]      LAT_LAST    = 3'(MEM_LAT - 1);

  state_t              state, state_nxt;
  logic [2:0]          lat_cnt;
  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W:0]     num_r;
  logic [RULE_W-1:0]   data_r;
  logic                hit_r;
  logic [ADDR_W-1:0]   hit_idx_r;

  logic start_ok;
  logic last_rule;
  logic data_last;

  // A start that coincides with an abort is dropped.
  assign start_ok  = cfg_start && !cfg_abort;
  assign last_rule = (({1'b0, idx}) + (ADDR_W+1)'(1)) == num_r;
  assign data_last = (lat_cnt == LAT_LAST);

  // State register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_ok) state_nxt = (cfg_num_rules == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH:     state_nxt = S_WAIT_DATA;
      S_WAIT_DATA: if (data_last) state_nxt = S_PRESENT;
      S_PRESENT:   if (rule_ready) state_nxt = S_WAIT_RESULT;
      S_WAIT_RESULT: begin
        if (match_valid) state_nxt = (match_hit || last_rule) ? S_DONE : S_FETCH;
      end
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
    if (cfg_abort) state_nxt = S_IDLE;
  end

  // Walk datapath
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      lat_cnt   <= '0;
      idx       <= '0;
      rd_addr   <= '0;
      num_r     <= '0;
      data_r    <= '0;
      hit_r     <= 1'b0;
      hit_idx_r <= '0;
    end else if (cfg_abort && state != S_IDLE) begin
      // Any RAM read still in flight is simply never captured.
      lat_cnt <= '0;
      idx     <= '0;
      rd_addr <= '0;
      data_r  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            hit_r     <= 1'b0;
            hit_idx_r <= '0;
            idx       <= '0;
            rd_addr   <= cfg_base_addr;
            num_r     <= (cfg_num_rules > TABLE_DEPTH) ? TABLE_DEPTH : cfg_num_rules;
          end
        end
        S_FETCH: lat_cnt <= '0;
        S_WAIT_DATA: begin
          lat_cnt <= lat_cnt + 3'd1;
          if (data_last) data_r <= mem_rd_data;
        end
        S_WAIT_RESULT: begin
          if (match_valid) begin
            if (match_hit) begin
              hit_r     <= 1'b1;
              hit_idx_r <= idx;
            end else if (!last_rule) begin
              idx     <= idx + 1'b1;
              rd_addr <= rd_addr + 1'b1;   // wraps at the top of the RAM
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: registers or state decodes only
  assign mem_rd_en   = (state == S_FETCH);
  assign mem_rd_addr = rd_addr;
  assign rule_valid  = (state == S_PRESENT);
  assign rule_data   = data_r;
  assign rule_index  = idx;
  assign busy        = (state != S_IDLE) && (state != S_DONE);
  assign done        = (state == S_DONE);
  assign hit         = hit_r;
  assign hit_index   = hit_idx_r;
  assign fsm_state   = state;

endmodule

// File: tb/tb_acl_rule_sequencer.sv
// ---------------------------------------------------------------------------
// tb_acl_rule_sequencer
//   Directed bench for acl_rule_sequencer (RULE_W=32, ADDR_W=8, MEM_LAT=1).
//   A RAM model answers reads one cycle later; a negedge responder plays the
//   match engine (ready, verdict, stalls) and records what the DUT presents.
// ---------------------------------------------------------------------------
module tb_acl_rule_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start, cfg_abort;
  logic [7:0]  cfg_base_addr;
  logic [8:0]  cfg_num_rules;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_addr;
  logic [31:0] mem_rd_data = '0;
  logic        rule_valid, rule_ready;
  logic [31:0] rule_data;
  logic [7:0]  rule_index;
  logic        match_valid, match_hit;
  logic        busy, done, hit;
  logic [7:0]  hit_index;
  logic [2:0]  fsm_state;

  acl_rule_sequencer #(.RULE_W(32), .ADDR_W(8), .MEM_LAT(1)) dut (
    .ACLK          (clk),
    .ARESETN       (rst_n),
    .cfg_start     (cfg_start),
    .cfg_abort     (cfg_abort),
    .cfg_base_addr (cfg_base_addr),
    .cfg_num_rules (cfg_num_rules),
    .mem_rd_en     (mem_rd_en),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_data   (mem_rd_data),
    .rule_valid    (rule_valid),
    .rule_ready    (rule_ready),
    .rule_data     (rule_data),
    .rule_index    (rule_index),
    .match_valid   (match_valid),
    .match_hit     (match_hit),
    .busy          (busy),
    .done          (done),
    .hit           (hit),
    .hit_index     (hit_index),
    .fsm_state     (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Rule RAM model, read latency 1
  logic [31:0] ram [256];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic [31:0] obs_data_q[$];
  logic [31:0] obs_idx_q[$];
  logic [31:0] obs_addr_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  int done_cnt, done_cyc, start_cyc, first_valid_cyc, rd_en_cnt;
  int stall_idx, stall_left, stall_valid_cycles, hit_target;
  int pending_idx;
  bit stall_seen, stall_err, busy_in_done, match_pending, ready_en;
  logic [31:0] stall_data;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_seq(input string tag, input int which);
    logic [31:0] o;
    int osz;
    osz = (which == 0) ? obs_data_q.size() : (which == 1) ? obs_idx_q.size() : obs_addr_q.size();
    check_eq({tag, "_len"}, osz, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < osz) begin
        o = (which == 0) ? obs_data_q[i] : (which == 1) ? obs_idx_q[i] : obs_addr_q[i];
        check_eq(tag, o, exp_q[i]);
      end
    end
  endtask

  task automatic clear_rec();
    obs_data_q.delete(); obs_idx_q.delete(); obs_addr_q.delete(); exp_q.delete();
    done_cnt = 0; done_cyc = -1; first_valid_cyc = -1; rd_en_cnt = 0;
    stall_idx = -1; stall_left = 0; stall_valid_cycles = 0; hit_target = -1;
    stall_seen = 0; stall_err = 0; busy_in_done = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [7:0] base, input logic [8:0] num);
    @(negedge clk);
    cfg_base_addr = base;
    cfg_num_rules = num;
    cfg_start     = 1'b1;
    start_cyc     = cyc;
    @(negedge clk);
    cfg_start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check_eq(tag, done_cnt, 1);
  endtask

  // Match engine: ready on the first valid cycle unless stalled; verdict
  // arrives one cycle after each transfer.
  initial begin
    rule_ready = 1'b0; match_valid = 1'b0; match_hit = 1'b0;
    match_pending = 0; pending_idx = 0;
    forever begin
      @(negedge clk);
      match_valid = 1'b0;
      match_hit   = 1'b0;
      rule_ready  = 1'b0;
      if (!rst_n) begin
        match_pending = 0;
      end else begin
        if (match_pending) begin
          match_valid   = 1'b1;
          match_hit     = (pending_idx == hit_target);
          match_pending = 0;
        end
        if (mem_rd_en) begin
          obs_addr_q.push_back({24'd0, mem_rd_addr});
          rd_en_cnt++;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          if (busy) busy_in_done = 1;
        end
        if (rule_valid) begin
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
          if (int'(rule_index) == stall_idx) begin
            stall_valid_cycles++;
            if (!stall_seen) begin
              stall_seen = 1;
              stall_data = rule_data;
            end else if (rule_data !== stall_data) begin
              stall_err = 1;
            end
          end
          if (int'(rule_index) == stall_idx && stall_left > 0) begin
            stall_left--;
          end else if (ready_en) begin
            rule_ready = 1'b1;
            obs_data_q.push_back(rule_data);
            obs_idx_q.push_back({24'd0, rule_index});
            match_pending = 1;
            pending_idx   = int'(rule_index);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    int n;
    int idx1_xfers;
    rst_n = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0;
    cfg_base_addr = '0; cfg_num_rules = '0;
    ready_en = 1;
    for (int i = 0; i < 256; i++) ram[i] = 32'(i + 1);
    clear_rec();
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_outs", {busy, done, hit, rule_valid, mem_rd_en}, 0);
    check_eq("rst_rule_data", rule_data, 0);
    check_eq("rst_hit_index", {hit_index, rule_index, mem_rd_addr}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: four misses
    clear_rec();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i + 1));
    pulse_start(8'h00, 9'd4);
    wait_done("t1_done", 100);
    check_seq("t1_data", 0);
    check_eq("t1_first_valid_lat", first_valid_cyc - start_cyc, 3);
    check_eq("t1_done_lat", done_cyc - start_cyc, 17);
    check_eq("t1_hit", hit, 0);
    check_eq("t1_busy_in_done", busy_in_done, 0);
    repeat (5) @(negedge clk);
    check_eq("t1_done_once", done_cnt, 1);
    check_eq("t1_busy_after", busy, 0);

    // T2: hit on rule 2
    clear_rec();
    hit_target = 2;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'(i + 1));
    pulse_start(8'h00, 9'd4);
    wait_done("t2_done", 100);
    check_seq("t2_data", 0);
    check_eq("t2_hit", hit, 1);
    check_eq("t2_hit_index", hit_index, 2);

    // T4: empty walk, also clears the previous hit
    clear_rec();
    pulse_start(8'h00, 9'd0);
    wait_done("t4_done", 10);
    check_eq("t4_done_lat", done_cyc - start_cyc, 1);
    check_eq("t4_hit", hit, 0);
    check_eq("t4_hit_index", hit_index, 0);
    check_eq("t4_rd_en_cnt", rd_en_cnt, 0);
    check_eq("t4_presented", obs_data_q.size(), 0);

    // T3: address wrap
    clear_rec();
    exp_q.push_back(32'hFE); exp_q.push_back(32'hFF);
    exp_q.push_back(32'h00); exp_q.push_back(32'h01);
    pulse_start(8'hFE, 9'd4);
    wait_done("t3_done", 100);
    check_seq("t3_addr", 2);
    exp_q.delete();
    exp_q.push_back(32'hFF); exp_q.push_back(32'h100);
    exp_q.push_back(32'h1);  exp_q.push_back(32'h2);
    check_seq("t3_data", 0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i));
    check_seq("t3_index", 1);

    // T5: stall on rule 1, stray start during the walk
    clear_rec();
    stall_idx  = 1;
    stall_left = 10;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'(i + 1));
    pulse_start(8'h00, 9'd3);
    repeat (5) @(negedge clk);
    cfg_base_addr = 8'h80; cfg_num_rules = 9'd2; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    wait_done("t5_done", 200);
    repeat (10) @(negedge clk);
    check_eq("t5_done_once", done_cnt, 1);
    check_seq("t5_data", 0);
    check_eq("t5_stable", stall_err, 0);
    check_eq("t5_stall_data", stall_data, 2);
    check_eq("t5_valid_cycles", stall_valid_cycles, 11);
    idx1_xfers = 0;
    foreach (obs_idx_q[i]) if (obs_idx_q[i] == 1) idx1_xfers++;
    check_eq("t5_idx1_xfers", idx1_xfers, 1);
    check_eq("t5_rd_en_cnt", rd_en_cnt, 3);
    check_eq("t5_busy_after", busy, 0);

    // T6a: abort in WAIT_DATA
    clear_rec();
    pulse_start(8'h00, 9'd4);
    @(negedge clk);
    check_eq("t6a_in_wait_data", fsm_state, 2);
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_abort = 1'b0;
    check_eq("t6a_state", fsm_state, 0);
    check_eq("t6a_outs", {busy, done, rule_valid, mem_rd_en, hit}, 0);
    check_eq("t6a_rule_data", rule_data, 0);
    repeat (10) @(negedge clk);
    check_eq("t6a_no_done", done_cnt, 0);
    check_eq("t6a_presented", obs_data_q.size(), 0);

    // Start and abort together: nothing starts
    clear_rec();
    cfg_base_addr = 8'h00; cfg_num_rules = 9'd4;
    cfg_start = 1'b1; cfg_abort = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0; cfg_abort = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("t6a_abort_wins", {busy, done}, 0);
    check_eq("t6a_abort_rd_en", rd_en_cnt, 0);

    // Normal walk after the abort
    clear_rec();
    exp_q.push_back(32'd1); exp_q.push_back(32'd2);
    pulse_start(8'h00, 9'd2);
    wait_done("t6a_rerun_done", 100);
    check_seq("t6a_rerun_data", 0);
    check_eq("t6a_rerun_hit", hit, 0);

    // T6b: reset while presenting
    clear_rec();
    ready_en = 0;
    pulse_start(8'h00, 9'd4);
    n = 0;
    while (!rule_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6b_present", rule_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("t6b_outs", {busy, done, rule_valid, mem_rd_en, hit}, 0);
    check_eq("t6b_rule_data", rule_data, 0);
    check_eq("t6b_state", fsm_state, 0);
    rst_n = 1'b1;
    ready_en = 1;
    repeat (2) @(negedge clk);
    check_eq("t6b_no_done", done_cnt, 0);

    clear_rec();
    hit_target = 0;
    exp_q.push_back(32'd1);
    pulse_start(8'h00, 9'd3);
    wait_done("t6b_rerun_done", 100);
    check_seq("t6b_rerun_data", 0);
    check_eq("t6b_rerun_hit", hit, 1);
    check_eq("t6b_rerun_hit_index", hit_index, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
